mem_port_arbiter: RTL

//  Shares one single-ported, fixed-latency unified memory between the fetch stage (read-only)
//  and the MEM stage (load/store) of the 5-stage CPU pipeline. Grants one transaction at a

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_lat_timer.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_port_arbiter_pkg
// Purpose  : Shared state and owner encodings for the fetch/data memory arbiter.
// Revision : 1.0
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int WORD = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_lat_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_lat_timer
// Purpose  : Counts 1..MEM_LAT after a start pulse; done marks the data-valid cycle.
// Revision : 1.0
// ============================================================================
module mem_lat_timer #(
    parameter int MEM_LAT = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Zero means idle; the count parks at zero again right after done.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_W'(MEM_LAT)) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_W'(MEM_LAT));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency single-ported memory between fetch and data ports.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 10,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_ack,
    output logic [WORD-1:0] if_rdata,
    output logic            if_stall,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [AW-1:0]   dm_addr,
    input  logic [WORD-1:0] dm_wdata,
    output logic            dm_ack,
    output logic [WORD-1:0] dm_rdata,
    output logic            dm_stall,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] mem_rdata
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    arb_state_e      state_q, state_d;
    owner_e          owner_q, owner_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [WORD-1:0] if_rdata_q, if_rdata_d;
    logic [WORD-1:0] dm_rdata_q, dm_rdata_d;
    logic            grant_if;
    logic            lat_done;

    mem_lat_timer #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_timer (
        .clock (clock),
        .reset (reset),
        .start (state_q == ST_CMD),
        .done  (lat_done)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        // Data port wins ties until fetch has lost STARVE_MAX times in a row.
        grant_if   = if_req && (!dm_req || (starve_q >= SW'(STARVE_MAX)));

        case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    state_d = ST_CMD;
                    if (grant_if) begin
                        owner_d  = OWN_IF;
                        we_d     = 1'b0;
                        addr_d   = if_addr;
                        wdata_d  = '0;
                        starve_d = '0;
                    end else begin
                        owner_d = OWN_DM;
                        we_d    = dm_we;
                        addr_d  = dm_addr;
                        wdata_d = dm_wdata;
                        if (if_req && (starve_q < SW'(STARVE_MAX))) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end
                end
            end
            ST_CMD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_done) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_en    = (state_q == ST_CMD);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ack    = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign dm_ack    = (state_q == ST_RESP) && (owner_q == OWN_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_stall  = if_req && !if_ack;
    assign dm_stall  = dm_req && !dm_ack;

    // Requesters must hold their request until acknowledged.
    a_if_req_held: assert property (@(posedge clock) disable iff (reset)
        (if_req && !if_ack) |=> if_req);
    a_dm_req_held: assert property (@(posedge clock) disable iff (reset)
        (dm_req && !dm_ack) |=> dm_req);
    a_one_ack: assert property (@(posedge clock) disable iff (reset)
        !(if_ack && dm_ack));

endmodule
`default_nettype wire
